// File: rtl/alu_writeback_stage.sv
// Writeback stage behind the ALU: buffers results in an in-order FIFO, drains them to the
// register-file write port under valid/ready, and owns the architectural Zero/Sign flags.
module alu_writeback_stage #(
    parameter int W     = 8,
    parameter int RA    = 4,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_zero,
    input  logic          in_sign,
    input  logic [RA-1:0] in_waddr,
    input  logic          in_we,
    input  logic          in_setf,
    input  logic          rf_ready,
    output logic          rf_we,
    output logic [RA-1:0] rf_waddr,
    output logic [W-1:0]  rf_wdata,
    output logic          zero_flag,
    output logic          sign_flag,
    output logic [CW-1:0] retired,
    output logic          busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [W-1:0]  data;
        logic          zero;
        logic          sign;
        logic [RA-1:0] waddr;
        logic          we;
        logic          setf;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [NW-1:0] r_count;
    logic          r_zf;
    logic          r_sf;
    logic [CW-1:0] r_retired;

    entry_t        w_head;
    entry_t        w_in;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_head  = r_mem[r_rptr];
    assign w_in    = '{data: in_data, zero: in_zero, sign: in_sign,
                       waddr: in_waddr, we: in_we, setf: in_setf};
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == NW'(DEPTH));

    // Acceptance depends only on occupancy, so rf_ready never reaches in_ready.
    assign w_push  = in_valid && !w_full;
    // Non-writing entries retire without waiting for the write port.
    assign w_pop   = !w_empty && (rf_ready || !w_head.we);

    assign in_ready  = Reset || !w_full;
    assign rf_we     = !Reset && !w_empty && w_head.we;
    assign rf_waddr  = w_empty ? '0 : w_head.waddr;
    assign rf_wdata  = w_empty ? '0 : w_head.data;
    assign busy      = !Reset && !w_empty;
    assign zero_flag = r_zf;
    assign sign_flag = r_sf;
    assign retired   = r_retired;

    // Payload storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge Clk) begin
        if (!Reset && w_push) begin
            r_mem[r_wptr] <= w_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_zf      <= 1'b0;
            r_sf      <= 1'b0;
            r_retired <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + AW'(1);
                r_retired <= r_retired + CW'(1);
                if (w_head.setf) begin
                    r_zf <= w_head.zero;
                    r_sf <= w_head.sign;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Pipeline stage directly downstream of the 8-bit ALU: captures each ALU result (out, Zero, Sign) with its destination register index and control bits.
- Buffers results in a small in-order FIFO and drains them to the register-file write port under a valid/ready handshake.
- Owns the architectural flag register (zero_flag, sign_flag) and a retired-operation counter.
- Absorbs register-file write-port stalls, for example when the port is shared with a load path.

Parameters:
W, 8, data width; matches ALU result width
RA, 4, register-file address width
DEPTH, 2, FIFO entries; power of two, >=2
CW, 16, width of retired-operation counter

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents a result this cycle
in_ready  output  1  stage can accept a result this cycle
in_data  input  W  ALU out
in_zero  input  1  ALU Zero
in_sign  input  1  ALU Sign
in_waddr  input  RA  destination register index
in_we  input  1  result is to be written to the register file
in_setf  input  1  result updates the flag register
rf_ready  input  1  register-file write port free this cycle
rf_we  output  1  register-file write enable
rf_waddr  output  RA  register-file write address
rf_wdata  output  W  register-file write data
zero_flag  output  1  architectural Zero flag
sign_flag  output  1  architectural Sign flag
retired  output  CW  count of entries popped since reset
busy  output  1  FIFO non-empty

Behaviour:
- Reset (sync, Reset=1 at edge): FIFO emptied, read and write pointers cleared, zero_flag=0, sign_flag=0, retired=0. Any in-flight entries are discarded with no write and no flag update. During and after reset: rf_we=0, busy=0, in_ready=1.
- Occupancy count is 0..DEPTH. full = (count==DEPTH); empty = (count==0).
- in_ready = !full. It is a function of registered state only, with no combinational path from rf_ready.
- Push: in_valid && in_ready at edge. Entry {in_data, in_zero, in_sign, in_waddr, in_we, in_setf} is written at the write pointer.
- Head outputs are combinational from the head entry:
  - rf_waddr = head.waddr; rf_wdata = head.data.
  - rf_we = !empty && head.we.
  - When empty, rf_waddr and rf_wdata are 0.
- Pop condition: !empty && (rf_ready || !head.we). Entries with we=0 never wait on rf_ready.
- On pop:
  - If head.setf, then zero_flag <= head.zero and sign_flag <= head.sign.
  - retired increments by 1, wrapping modulo 2^CW.
- Latency: an entry accepted at edge N is at the head from cycle N+1 when the FIFO was empty. It earliest pops at edge N+1, so the flags are visible after N+1.
- Simultaneous push and pop:
  - Not full: both take effect and count is unchanged.
  - Full: in_ready=0, so only the pop occurs. There is no same-cycle pass-through.
- Pointers wrap modulo DEPTH. Ordering is strictly FIFO.
- in_valid while full: no push. Upstream holds its data; this stage does not drop or latch it.
- Stall: while rf_ready=0 and head.we=1, the head entry, rf_we, rf_waddr and rf_wdata remain stable.
- busy = !empty.
- Inputs are ignored when in_valid=0.

Test Plan:
- Reset then single push: {data=0x2A, zero=0, sign=0, waddr=3, we=1, setf=1} with rf_ready=1 -> rf_we=1, rf_waddr=3, rf_wdata=0x2A for exactly one cycle; then zero_flag=0, sign_flag=0, retired=1, busy=0.
- Back-pressure with rf_ready=0: push 0x10 (waddr=1) and 0x20 (waddr=2) -> in_ready=0 after the second push. Third in_valid with 0x30 is not accepted and rf outputs hold 1/0x10. Raise rf_ready -> writes 0x10, then 0x20, in order; in_ready returns to 1 after the first pop.
- Non-writing entry: push {data=0x00, zero=1, we=0, setf=1} with rf_ready=0 -> pops next cycle regardless, rf_we stays 0, zero_flag=1, retired increments.
- Flag hold: push {zero=1, setf=1} then {data=0x05, zero=0, sign=1, setf=0} -> after both pops zero_flag=1 and sign_flag=0, unchanged by the second entry.
- Reset mid-operation: FIFO full and stalled, assert Reset for one cycle -> next cycle busy=0, rf_we=0, flags=0, retired=0, in_ready=1. The discarded entries are never written.
- Throughput and wrap: rf_ready=1, in_valid=1 every cycle for 20 pushes of data=i -> one write per cycle in order 0..19, retired=20. Separately, preload retired to 0xFFFF and pop once -> retired=0x0000.
